// File: rtl/timx_etr_cond_if.sv
// ETR conditioning bundle: raw pin, SMCR/CR1 configuration fields and the
// conditioned outputs.
//   master: drives timx_etr and cfg_*, observes etrp/etrf/etrf_rise/etrf_fall
//   slave : the conditioning stage itself
interface timx_etr_cond_if;
  logic       timx_etr;   // raw ETR pin, asynchronous
  logic       cfg_en;     // path enable (ECE or SMS==111)
  logic       cfg_etp;    // polarity invert
  logic [1:0] cfg_etps;   // prescaler select
  logic [3:0] cfg_etf;    // filter code
  logic [1:0] cfg_ckd;    // fDTS divider
  logic       etrp;       // polarity-corrected, prescaled level
  logic       etrf;       // filtered level
  logic       etrf_rise;  // one-cycle pulse on etrf 0->1
  logic       etrf_fall;  // one-cycle pulse on etrf 1->0

  modport master (
    output timx_etr, cfg_en, cfg_etp, cfg_etps, cfg_etf, cfg_ckd,
    input  etrp, etrf, etrf_rise, etrf_fall
  );

  modport slave (
    input  timx_etr, cfg_en, cfg_etp, cfg_etps, cfg_etf, cfg_ckd,
    output etrp, etrf, etrf_rise, etrf_fall
  );
endinterface

// File: rtl/timx_etr_cond.sv
// External trigger input conditioning: 2-flop synchronizer, polarity,
// edge-counting prescaler, sampled digital filter and edge pulse outputs.
// Ports:
//   apb_clk - timer kernel clock
//   apb_rst - asynchronous active-high reset
//   bus     - timx_etr_cond_if.slave (pin, cfg_* in; etrp, etrf, pulses out)
module timx_etr_cond (
  input logic             apb_clk,
  input logic             apb_rst,
  timx_etr_cond_if.slave  bus
);

  logic       s1_q, s2_q, pol_d_q, en_d_q;
  logic [2:0] pcnt_q, fcnt_q;
  logic [7:0] dcnt_q;
  logic [7:0] cfg_q;
  logic       etrp_q, etrf_q, rise_q, fall_q;

  logic [7:0] cfg_now;
  logic       cfg_chg, pol, pol_rise;
  logic [2:0] ckd_sh, f_sh, d_sh, n_m1, fcnt_next;
  logic [7:0] d_lim;
  logic       smp_en, smp_act, etrp_next, etrf_next;

  assign cfg_now  = {bus.cfg_etps, bus.cfg_etf, bus.cfg_ckd};
  // Any prescaler/filter/divider change restarts the filter window.
  assign cfg_chg  = bus.cfg_en & (cfg_now != cfg_q);
  assign pol      = s2_q ^ bus.cfg_etp;
  assign pol_rise = pol & ~pol_d_q & bus.cfg_en & en_d_q;

  always_comb begin
    ckd_sh = 3'd0;
    unique case (bus.cfg_ckd)
      2'b01:   ckd_sh = 3'd1;
      2'b10:   ckd_sh = 3'd2;
      default: ckd_sh = 3'd0;
    endcase

    f_sh = 3'd0;
    n_m1 = 3'd0;
    unique case (bus.cfg_etf)
      4'h0: begin f_sh = 3'd0; n_m1 = 3'd0; end
      4'h1: begin f_sh = 3'd0; n_m1 = 3'd1; end
      4'h2: begin f_sh = 3'd0; n_m1 = 3'd3; end
      4'h3: begin f_sh = 3'd0; n_m1 = 3'd7; end
      4'h4: begin f_sh = 3'd1; n_m1 = 3'd5; end
      4'h5: begin f_sh = 3'd1; n_m1 = 3'd7; end
      4'h6: begin f_sh = 3'd2; n_m1 = 3'd5; end
      4'h7: begin f_sh = 3'd2; n_m1 = 3'd7; end
      4'h8: begin f_sh = 3'd3; n_m1 = 3'd5; end
      4'h9: begin f_sh = 3'd3; n_m1 = 3'd7; end
      4'hA: begin f_sh = 3'd4; n_m1 = 3'd4; end
      4'hB: begin f_sh = 3'd4; n_m1 = 3'd5; end
      4'hC: begin f_sh = 3'd4; n_m1 = 3'd7; end
      4'hD: begin f_sh = 3'd5; n_m1 = 3'd4; end
      4'hE: begin f_sh = 3'd5; n_m1 = 3'd5; end
      default: begin f_sh = 3'd5; n_m1 = 3'd7; end
    endcase

    // D = 2^(ckd_sh + f_sh), at most 128.
    d_sh    = ckd_sh + f_sh;
    d_lim   = (8'd1 << d_sh) - 8'd1;
    smp_en  = (dcnt_q == d_lim);
    // A sample coinciding with a config change is thrown away.
    smp_act = smp_en & bus.cfg_en & ~cfg_chg;

    etrp_next = pol;
    unique case (bus.cfg_etps)
      2'b00: etrp_next = pol;
      2'b01: etrp_next = pcnt_q[0];
      2'b10: etrp_next = pcnt_q[1];
      2'b11: etrp_next = pcnt_q[2];
      default: etrp_next = pol;
    endcase

    etrf_next = etrf_q;
    fcnt_next = fcnt_q;
    if (cfg_chg) begin
      fcnt_next = 3'd0;
    end else if (smp_act) begin
      if (etrp_q != etrf_q) begin
        if (fcnt_q == n_m1) begin
          etrf_next = ~etrf_q;
          fcnt_next = 3'd0;
        end else begin
          fcnt_next = fcnt_q + 3'd1;
        end
      end else begin
        fcnt_next = 3'd0;
      end
    end
  end

  always_ff @(posedge apb_clk or posedge apb_rst) begin
    if (apb_rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      pol_d_q <= 1'b0;
      en_d_q  <= 1'b0;
      cfg_q   <= 8'd0;
      pcnt_q  <= 3'd0;
      fcnt_q  <= 3'd0;
      dcnt_q  <= 8'd0;
      etrp_q  <= 1'b0;
      etrf_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      // Synchronizer and edge history run regardless of enable.
      s1_q    <= bus.timx_etr;
      s2_q    <= s1_q;
      pol_d_q <= pol;
      en_d_q  <= bus.cfg_en;
      cfg_q   <= cfg_now;
      if (!bus.cfg_en) begin
        pcnt_q <= 3'd0;
        fcnt_q <= 3'd0;
        dcnt_q <= 8'd0;
        etrp_q <= 1'b0;
        etrf_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        if (pol_rise) pcnt_q <= pcnt_q + 3'd1;
        dcnt_q <= (cfg_chg || smp_en) ? 8'd0 : dcnt_q + 8'd1;
        // Hold etrp across a config change so a prescaler switch cannot glitch it.
        if (!cfg_chg) etrp_q <= etrp_next;
        fcnt_q <= fcnt_next;
        etrf_q <= etrf_next;
        rise_q <= etrf_next & ~etrf_q;
        fall_q <= ~etrf_next & etrf_q;
      end
    end
  end

  assign bus.etrp      = etrp_q;
  assign bus.etrf      = etrf_q;
  assign bus.etrf_rise = rise_q;
  assign bus.etrf_fall = fall_q;

endmodule

// File: tb/tb_timx_etr_cond.sv
// Directed bench for timx_etr_cond. Inputs change 1 time unit after a rising
// clock edge; outputs are sampled at the same point, so "after edge e+n"
// below means the value registered at that edge.
module tb_timx_etr_cond;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  timx_etr_cond_if ifc ();

  timx_etr_cond dut (
    .apb_clk (clk),
    .apb_rst (rst),
    .bus     (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Disable, load new config while idle so no change is seen when enabled.
  task automatic reconfig(input logic etp, input logic [1:0] etps, input logic [3:0] etf,
                          input logic [1:0] ckd);
    ifc.cfg_en = 1'b0;
    tick(1);
    ifc.cfg_etp  = etp;
    ifc.cfg_etps = etps;
    ifc.cfg_etf  = etf;
    ifc.cfg_ckd  = ckd;
    tick(2);
    ifc.cfg_en = 1'b1;
  endtask

  task automatic test_reset();
    tick(2);
    n_tests++; if (ifc.etrp !== 1'b0) begin n_fail++; $display("FAIL reset_etrp got=%b exp=0", ifc.etrp); end
    n_tests++; if (ifc.etrf !== 1'b0) begin n_fail++; $display("FAIL reset_etrf got=%b exp=0", ifc.etrf); end
    n_tests++; if (ifc.etrf_rise !== 1'b0) begin n_fail++; $display("FAIL reset_rise got=%b exp=0", ifc.etrf_rise); end
    n_tests++; if (ifc.etrf_fall !== 1'b0) begin n_fail++; $display("FAIL reset_fall got=%b exp=0", ifc.etrf_fall); end
    rst = 1'b0;
  endtask

  // /1, bypass: etrp at e+3, etrf and rise at e+4 after driving the pin at e.
  task automatic test_bypass();
    ifc.cfg_en = 1'b1;
    tick(4);
    for (int p = 0; p < 3; p++) begin
      ifc.timx_etr = 1'b1;
      tick(3);
      n_tests++; if (ifc.etrp !== 1'b1 || ifc.etrf !== 1'b0) begin
        n_fail++; $display("FAIL bypass_etrp p=%0d etrp=%b etrf=%b exp=1/0", p, ifc.etrp, ifc.etrf); end
      tick(1);
      n_tests++; if (ifc.etrf !== 1'b1 || ifc.etrf_rise !== 1'b1) begin
        n_fail++; $display("FAIL bypass_rise p=%0d etrf=%b rise=%b exp=1/1", p, ifc.etrf, ifc.etrf_rise); end
      tick(1);
      n_tests++; if (ifc.etrf_rise !== 1'b0) begin
        n_fail++; $display("FAIL bypass_rise_width p=%0d rise=%b exp=0", p, ifc.etrf_rise); end
      tick(5);
      ifc.timx_etr = 1'b0;
      tick(4);
      n_tests++; if (ifc.etrf !== 1'b0 || ifc.etrf_fall !== 1'b1) begin
        n_fail++; $display("FAIL bypass_fall p=%0d etrf=%b fall=%b exp=0/1", p, ifc.etrf, ifc.etrf_fall); end
      tick(6);
    end
  endtask

  // /4: etrf follows pcnt[1]; rises after pin rises #2 and #6 (index 25, 105).
  task automatic test_prescale();
    int rises = 0, falls = 0, high = 0, first = 0, second = 0;
    reconfig(1'b0, 2'b10, 4'h0, 2'b00);
    tick(4);
    for (int p = 0; p < 8; p++) begin
      ifc.timx_etr = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        tick(1);
        if (ifc.etrf === 1'b1) high++;
        if (ifc.etrf_fall === 1'b1) falls++;
        if (ifc.etrf_rise === 1'b1) begin
          rises++;
          if (first == 0) first = 20 * p + c; else second = 20 * p + c;
        end
        if (c == 10) ifc.timx_etr = 1'b0;
      end
    end
    n_tests++; if (rises != 2) begin n_fail++; $display("FAIL psc_rises got=%0d exp=2", rises); end
    n_tests++; if (falls != 2) begin n_fail++; $display("FAIL psc_falls got=%0d exp=2", falls); end
    n_tests++; if (high != 80) begin n_fail++; $display("FAIL psc_high got=%0d exp=80", high); end
    n_tests++; if (first != 25) begin n_fail++; $display("FAIL psc_first got=%0d exp=25", first); end
    n_tests++; if (second - first != 80) begin
      n_fail++; $display("FAIL psc_period got=%0d exp=80", second - first); end
  endtask

  task automatic test_polarity();
    reconfig(1'b1, 2'b00, 4'h0, 2'b00);
    // Pin idle low, inverted: etrp rises on the first enabled edge.
    tick(1);
    n_tests++; if (ifc.etrp !== 1'b1 || ifc.etrf !== 1'b0) begin
      n_fail++; $display("FAIL pol_enable etrp=%b etrf=%b exp=1/0", ifc.etrp, ifc.etrf); end
    tick(1);
    n_tests++; if (ifc.etrf_rise !== 1'b1) begin
      n_fail++; $display("FAIL pol_enable_rise got=%b exp=1", ifc.etrf_rise); end
    tick(3);
    ifc.timx_etr = 1'b1;
    tick(4);
    n_tests++; if (ifc.etrf !== 1'b0 || ifc.etrf_fall !== 1'b1) begin
      n_fail++; $display("FAIL pol_pin_rise etrf=%b fall=%b exp=0/1", ifc.etrf, ifc.etrf_fall); end
    tick(6);
    ifc.timx_etr = 1'b0;
    tick(3);
    n_tests++; if (ifc.etrf_rise !== 1'b0) begin
      n_fail++; $display("FAIL pol_early_rise got=%b exp=0", ifc.etrf_rise); end
    tick(1);
    n_tests++; if (ifc.etrf_rise !== 1'b1) begin
      n_fail++; $display("FAIL pol_pin_fall_rise got=%b exp=1", ifc.etrf_rise); end
  endtask

  // N=8, D=1: 5-cycle pulse rejected; 12-cycle pulse gives rise e+11, fall e+23.
  task automatic test_filter_n8();
    int pulses = 0, rise_at = 0, fall_at = 0;
    reconfig(1'b0, 2'b00, 4'h3, 2'b00);
    tick(4);
    ifc.timx_etr = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick(1);
      if (c == 5) ifc.timx_etr = 1'b0;
      if (ifc.etrf_rise === 1'b1 || ifc.etrf_fall === 1'b1 || ifc.etrf === 1'b1) pulses++;
    end
    n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL filt_short got=%0d exp=0", pulses); end
    ifc.timx_etr = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick(1);
      if (ifc.etrf_rise === 1'b1) rise_at = c;
      if (ifc.etrf_fall === 1'b1) fall_at = c;
      if (c == 12) ifc.timx_etr = 1'b0;
    end
    n_tests++; if (rise_at != 11) begin n_fail++; $display("FAIL filt_rise_at got=%0d exp=11", rise_at); end
    n_tests++; if (fall_at != 23) begin n_fail++; $display("FAIL filt_fall_at got=%0d exp=23", fall_at); end
  endtask

  // N=8, D=128: 8th sample lands 897..1024 cycles after etrp (etrp at e+3).
  task automatic test_slow_filter();
    int rise_at = 0, fall_at = 0, bad = 0;
    reconfig(1'b0, 2'b00, 4'hF, 2'b10);
    tick(4);
    ifc.timx_etr = 1'b1;
    for (int c = 1; c <= 1500; c++) begin
      tick(1);
      if (ifc.etrf_rise === 1'b1 && rise_at == 0) rise_at = c;
    end
    n_tests++; if (rise_at < 900 || rise_at > 1027) begin
      n_fail++; $display("FAIL slow_rise_at got=%0d exp=900..1027", rise_at); end
    ifc.timx_etr = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      tick(1);
      if (ifc.etrf_fall === 1'b1 && fall_at == 0) fall_at = c;
    end
    n_tests++; if (fall_at < 900 || fall_at > 1027) begin
      n_fail++; $display("FAIL slow_fall_at got=%0d exp=900..1027", fall_at); end
    ifc.timx_etr = 1'b1;
    for (int c = 1; c <= 1700; c++) begin
      tick(1);
      if (c == 600) ifc.timx_etr = 1'b0;
      if (ifc.etrf === 1'b1) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL slow_reject got=%0d exp=0", bad); end
  endtask

  task automatic test_disable();
    reconfig(1'b0, 2'b00, 4'h0, 2'b00);
    ifc.timx_etr = 1'b1;
    tick(6);
    n_tests++; if (ifc.etrf !== 1'b1) begin n_fail++; $display("FAIL dis_pre etrf=%b exp=1", ifc.etrf); end
    ifc.cfg_en = 1'b0;
    tick(1);
    n_tests++; if (ifc.etrp !== 1'b0 || ifc.etrf !== 1'b0 || ifc.etrf_rise !== 1'b0
                   || ifc.etrf_fall !== 1'b0) begin
      n_fail++; $display("FAIL dis_clear etrp=%b etrf=%b rise=%b fall=%b exp=0000",
                         ifc.etrp, ifc.etrf, ifc.etrf_rise, ifc.etrf_fall); end
    ifc.timx_etr = 1'b0;
    tick(3);
    ifc.cfg_en = 1'b1;
    tick(3);
    ifc.timx_etr = 1'b1;
    tick(3);
    n_tests++; if (ifc.etrf !== 1'b0) begin n_fail++; $display("FAIL reen_early etrf=%b exp=0", ifc.etrf); end
    tick(1);
    n_tests++; if (ifc.etrf !== 1'b1 || ifc.etrf_rise !== 1'b1) begin
      n_fail++; $display("FAIL reen_rise etrf=%b rise=%b exp=1/1", ifc.etrf, ifc.etrf_rise); end
  endtask

  task automatic test_async_reset();
    tick(2);
    n_tests++; if (ifc.etrf !== 1'b1) begin n_fail++; $display("FAIL ar_pre etrf=%b exp=1", ifc.etrf); end
    #2;
    rst = 1'b1;
    #1;
    n_tests++; if (ifc.etrp !== 1'b0 || ifc.etrf !== 1'b0 || ifc.etrf_rise !== 1'b0
                   || ifc.etrf_fall !== 1'b0) begin
      n_fail++; $display("FAIL ar_clear etrp=%b etrf=%b rise=%b fall=%b exp=0000",
                         ifc.etrp, ifc.etrf, ifc.etrf_rise, ifc.etrf_fall); end
    tick(2);
    rst = 1'b0;
    // Pin is already high: it is captured at the next edge like a fresh rise.
    tick(3);
    n_tests++; if (ifc.etrp !== 1'b1 || ifc.etrf !== 1'b0) begin
      n_fail++; $display("FAIL ar_etrp etrp=%b etrf=%b exp=1/0", ifc.etrp, ifc.etrf); end
    tick(1);
    n_tests++; if (ifc.etrf !== 1'b1 || ifc.etrf_rise !== 1'b1) begin
      n_fail++; $display("FAIL ar_rise etrf=%b rise=%b exp=1/1", ifc.etrf, ifc.etrf_rise); end
  endtask

  // N=8 -> N=4 after three counted samples: the change clears fcnt and drops
  // the e+7 sample, so four fresh samples give the rise at e+11.
  task automatic test_cfg_change();
    int rise_at = 0;
    reconfig(1'b0, 2'b00, 4'h3, 2'b00);
    ifc.timx_etr = 1'b0;
    tick(12);
    ifc.timx_etr = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      if (ifc.etrf_rise === 1'b1 && rise_at == 0) rise_at = c;
      if (c == 6) ifc.cfg_etf = 4'h2;
      if (c == 7) begin
        n_tests++; if (ifc.etrp !== 1'b1 || ifc.etrf !== 1'b0) begin
          n_fail++; $display("FAIL chg_hold etrp=%b etrf=%b exp=1/0", ifc.etrp, ifc.etrf); end
      end
    end
    n_tests++; if (rise_at != 11) begin n_fail++; $display("FAIL chg_rise_at got=%0d exp=11", rise_at); end
  endtask

  initial begin
    ifc.timx_etr = 1'b0;
    ifc.cfg_en   = 1'b0;
    ifc.cfg_etp  = 1'b0;
    ifc.cfg_etps = 2'b00;
    ifc.cfg_etf  = 4'h0;
    ifc.cfg_ckd  = 2'b00;
    #1;
    test_reset();
    test_bypass();
    test_prescale();
    test_polarity();
    test_filter_n8();
    test_slow_filter();
    test_disable();
    test_async_reset();
    test_cfg_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
